upload_arbiter: RTL and testbench

UPLOAD_ARBITER -- requirements
Module: upload_arbiter

---
 rtl/upload_arbiter.sv | 130 +++++++++++++
 tb/tb_upload_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/upload_arbiter.sv
// rtl/upload_arbiter.sv - two-channel frame upload arbiter with fair tie-break, timeout and inter-frame gap
module upload_arbiter #(
    parameter int FRAME_LEN  = 512,
    parameter int TIMEOUT    = 4096,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Upload_En,
    input  logic        req_1,
    input  logic        req_2,
    input  logic [63:0] data_in_1,
    input  logic [63:0] data_in_2,
    input  logic        data_valid_i1,
    input  logic        data_valid_i2,
    output logic        upload_start_1,
    output logic        upload_start_2,
    output logic [63:0] data_out,
    output logic        data_valid_o,
    output logic [1:0]  grant,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int WCW = $clog2(FRAME_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    logic [1:0]     state;
    logic           last_ch2;
    logic [WCW-1:0] word_cnt;
    logic [TW-1:0]  timer;
    logic [GW-1:0]  gap_cnt;

    logic           pick_ch1;
    logic           sel_valid;
    logic [63:0]    sel_data;
    logic           frame_end;
    logic           time_end;

    // On a tie the channel that was not served last wins
    assign pick_ch1  = req_1 && (!req_2 || last_ch2);
    assign sel_valid = grant[0] ? data_valid_i1 : (grant[1] ? data_valid_i2 : 1'b0);
    assign sel_data  = grant[1] ? data_in_2 : data_in_1;
    assign frame_end = sel_valid && (word_cnt == WCW'(FRAME_LEN - 1));
    assign time_end  = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            last_ch2       <= 1'b1;
            word_cnt       <= '0;
            timer          <= '0;
            gap_cnt        <= '0;
            upload_start_1 <= 1'b0;
            upload_start_2 <= 1'b0;
            data_out       <= 64'd0;
            data_valid_o   <= 1'b0;
            grant          <= 2'b00;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
            frame_cnt      <= 16'd0;
        end else begin
            upload_start_1 <= 1'b0;
            upload_start_2 <= 1'b0;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
            data_valid_o   <= 1'b0;
            if (!Upload_En) begin
                state    <= S_IDLE;
                grant    <= 2'b00;
                word_cnt <= '0;
                timer    <= '0;
                gap_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_1 || req_2) begin
                            state          <= S_START;
                            grant          <= pick_ch1 ? 2'b01 : 2'b10;
                            upload_start_1 <= pick_ch1;
                            upload_start_2 <= !pick_ch1;
                            word_cnt       <= '0;
                        end
                    end
                    S_START: begin
                        state    <= S_XFER;
                        word_cnt <= '0;
                        timer    <= '0;
                    end
                    S_XFER: begin
                        data_out     <= sel_data;
                        data_valid_o <= sel_valid;
                        timer        <= timer + TW'(1);
                        if (sel_valid) begin
                            word_cnt <= word_cnt + WCW'(1);
                        end
                        // Completion takes priority over a simultaneous timeout
                        if (frame_end || time_end) begin
                            state    <= S_GAP;
                            grant    <= 2'b00;
                            gap_cnt  <= '0;
                            last_ch2 <= grant[1];
                            if (frame_end) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                            end else begin
                                timeout_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upload_arbiter.sv
// tb/tb_upload_arbiter.sv - scoreboard bench for upload_arbiter
module tb_upload_arbiter;

    localparam int FRAME_LEN  = 512;
    localparam int TIMEOUT    = 4096;
    localparam int GAP_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Upload_En = 1'b0;
    logic        req_1 = 1'b0;
    logic        req_2 = 1'b0;
    logic [63:0] data_in_1 = 64'd0;
    logic [63:0] data_in_2 = 64'd0;
    logic        data_valid_i1 = 1'b0;
    logic        data_valid_i2 = 1'b0;
    logic        upload_start_1;
    logic        upload_start_2;
    logic [63:0] data_out;
    logic        data_valid_o;
    logic [1:0]  grant;
    logic        frame_done;
    logic        timeout_err;
    logic [15:0] frame_cnt;

    upload_arbiter #(
        .FRAME_LEN(FRAME_LEN),
        .TIMEOUT(TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Upload_En(Upload_En),
        .req_1(req_1),
        .req_2(req_2),
        .data_in_1(data_in_1),
        .data_in_2(data_in_2),
        .data_valid_i1(data_valid_i1),
        .data_valid_i2(data_valid_i2),
        .upload_start_1(upload_start_1),
        .upload_start_2(upload_start_2),
        .data_out(data_out),
        .data_valid_o(data_valid_o),
        .grant(grant),
        .frame_done(frame_done),
        .timeout_err(timeout_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_data[$];
    int          exp_grant[$];
    int          done_cnt = 0;
    int          to_cnt = 0;
    int          vout_cnt = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          to_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=no_event", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data or a start pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid_o) begin
                vout_cnt++;
                if (exp_data.size() == 0) fail("unexpected_valid");
                else check("data_out", data_out, exp_data.pop_front());
            end
            if (upload_start_1 || upload_start_2) begin
                start_cyc = cyc;
                check("start_exclusive", {63'd0, upload_start_1 & upload_start_2}, 64'd0);
                check("start_vs_grant", {62'd0, grant}, {62'd0, upload_start_2, upload_start_1});
                if (exp_grant.size() == 0) fail("unexpected_start");
                else check("grant_owner", {62'd0, grant}, (exp_grant.pop_front() == 1) ? 64'd1 : 64'd2);
            end
            if (frame_done) done_cnt++;
            if (timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (frame_done && timeout_err) fail("done_with_timeout");
            check("grant_onehot", {63'd0, ($countones(grant) <= 1)}, 64'd1);
        end
    end

    // Returns negedges waited before the start pulse; leaves time at the first XFER cycle
    task automatic wait_start(output int idle);
        idle = -1;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (upload_start_1 || upload_start_2) begin
                idle = i;
                break;
            end
        end
        if (idle < 0) fail("start_wait_expired");
        @(posedge clk);
        #1;
    endtask

    // The non-granted channel toggles its valid with junk data throughout
    task automatic send_words(input int ch, input int n, input int base, input bit push);
        logic [63:0] d;
        for (int k = 1; k <= n; k++) begin
            d = 64'(base + k);
            if (ch == 1) begin
                data_in_1 = d; data_valid_i1 = 1'b1;
                data_in_2 = ~d; data_valid_i2 = k[0];
            end else begin
                data_in_2 = d; data_valid_i2 = 1'b1;
                data_in_1 = ~d; data_valid_i1 = k[0];
            end
            if (push) exp_data.push_back(d);
            @(posedge clk);
            #1;
        end
        data_valid_i1 = 1'b0;
        data_valid_i2 = 1'b0;
    endtask

    int idle;
    int base_done;
    int base_vout;
    int base_to;
    int chs[3] = '{1, 2, 1};

    initial begin
        Upload_En = 1'b1;
        #12;
        check("rst_data_out", data_out, 64'd0);
        check("rst_grant", {62'd0, grant}, 64'd0);
        check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        check("rst_valid_o", {63'd0, data_valid_o}, 64'd0);
        check("rst_starts", {62'd0, upload_start_2, upload_start_1}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both requests held: grants alternate starting with ch1
        req_1 = 1'b1; req_2 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            exp_grant.push_back(chs[f]);
            wait_start(idle);
            if (f > 0) check("gap_idle_cycles", 64'(idle), 64'(GAP_CYCLES + 1));
            send_words(chs[f], FRAME_LEN, (f + 1) * 1000, 1'b1);
        end
        req_1 = 1'b0; req_2 = 1'b0;
        repeat (4) @(negedge clk);
        check("frame_cnt_3", {48'd0, frame_cnt}, 64'd3);
        check("done_cnt_3", 64'(done_cnt), 64'd3);
        repeat (GAP_CYCLES + 2) @(posedge clk);
        #1;

        // ch1 only, data = k, request dropped after grant, extra valids ignored
        base_vout = vout_cnt;
        req_1 = 1'b1;
        exp_grant.push_back(1);
        wait_start(idle);
        req_1 = 1'b0;
        send_words(1, FRAME_LEN, 0, 1'b1);
        send_words(1, 3, 9000, 1'b0);
        repeat (3) @(negedge clk);
        check("vout_count", 64'(vout_cnt - base_vout), 64'(FRAME_LEN));
        check("frame_cnt_4", {48'd0, frame_cnt}, 64'd4);
        repeat (GAP_CYCLES + 2) @(posedge clk);
        #1;

        // Timeout: ch2 wins the tie, sends 100 words then stalls
        base_to = to_cnt;
        req_1 = 1'b1; req_2 = 1'b1;
        exp_grant.push_back(2);
        wait_start(idle);
        send_words(2, 100, 20000, 1'b1);
        for (int i = 0; i < TIMEOUT + 200 && to_cnt == base_to; i++) @(negedge clk);
        check("timeout_seen", 64'(to_cnt - base_to), 64'd1);
        check("timeout_latency", 64'(to_cyc - start_cyc), 64'(TIMEOUT + 1));
        check("frame_cnt_after_to", {48'd0, frame_cnt}, 64'd4);

        // Next grant goes to ch1; Upload_En dropped at word 200
        exp_grant.push_back(1);
        wait_start(idle);
        req_2 = 1'b0;
        base_done = done_cnt;
        send_words(1, 200, 30000, 1'b1);
        Upload_En = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("dis_grant", {62'd0, grant}, 64'd0);
        check("dis_valid_o", {63'd0, data_valid_o}, 64'd0);
        check("dis_data_hold", data_out, 64'(30200));
        repeat (4) @(negedge clk);
        check("dis_no_done", 64'(done_cnt), 64'(base_done));
        @(posedge clk); #1;
        exp_grant.push_back(1);
        Upload_En = 1'b1;
        wait_start(idle);
        req_1 = 1'b0;
        send_words(1, FRAME_LEN - 1, 40000, 1'b1);
        repeat (2) @(negedge clk);
        check("reen_no_early_done", 64'(done_cnt), 64'(base_done));
        @(posedge clk); #1;
        send_words(1, 1, 40000 + FRAME_LEN - 1, 1'b1);
        repeat (3) @(negedge clk);
        check("reen_done", 64'(done_cnt), 64'(base_done + 1));
        check("frame_cnt_5", {48'd0, frame_cnt}, 64'd5);
        repeat (GAP_CYCLES + 2) @(posedge clk);
        #1;

        // Asynchronous reset mid-transfer, then grant on the first edge after release
        req_1 = 1'b1;
        exp_grant.push_back(1);
        wait_start(idle);
        req_1 = 1'b0;
        send_words(1, 50, 50000, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_data.delete();
        #1;
        check("arst_data_out", data_out, 64'd0);
        check("arst_valid_o", {63'd0, data_valid_o}, 64'd0);
        check("arst_grant", {62'd0, grant}, 64'd0);
        check("arst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        @(negedge clk);
        req_1 = 1'b1;
        exp_grant.push_back(1);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_edge_grant", {62'd0, grant}, 64'd1);
        check("first_edge_start", {63'd0, upload_start_1}, 64'd1);
        req_1 = 1'b0;
        Upload_En = 1'b0;
        repeat (4) @(negedge clk);
        check("data_queue_empty", 64'(exp_data.size()), 64'd0);
        check("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
